vr_filter: RTL and testbench

Conditioning stage directly upstream of the `hwag` angle generator. It takes the raw crank VR comparator output, synchronizes it, rejects glitches with a programmable-length level filter, and suppresses noise edges inside a blanking window derived from the tooth period. It drives the clean `cap` level that `hwag` consumes, along with an edge strobe, the measured tooth period and a stall flag.

---
 rtl/vr_filter_pkg.sv | 17 +
 rtl/vr_glitch_filter.sv | 51 +++++
 rtl/vr_filter.sv | 177 +++++++++++++++++
 tb/tb_vr_filter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr_filter_pkg.sv
// Shared constants and types for the crank VR input conditioning stage.
package vr_filter_pkg;

    localparam int FILT_W_DEF = 4;
    localparam int PER_W_DEF  = 24;
    localparam int REJ_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/vr_glitch_filter.sv
// Two-flop synchronizer on the raw comparator output followed by a level
// filter: the output level only changes after filt_len+1 consecutive
// synchronized samples disagree with it.
module vr_glitch_filter
    import vr_filter_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_in,
    input  logic [FILT_W-1:0] filt_len,
    output logic              cap,
    output logic              toggle
);

    logic              s_meta;
    logic              s;
    logic [FILT_W-1:0] fc;

    // Toggle fires on the cycle that completes the run of disagreeing samples;
    // filt_len is compared live so a mid-count change applies immediately.
    assign toggle = (s != cap) && (fc >= filt_len);

    // Bring the asynchronous comparator output into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else begin
            s_meta <= cap_in;
            s      <= s_meta;
        end
    end

    // Count consecutive disagreeing samples and flip the level at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap <= 1'b0;
            fc  <= '0;
        end else if (s == cap) begin
            fc <= '0;
        end else if (toggle) begin
            cap <= ~cap;
            fc  <= '0;
        end else begin
            fc <= fc + FILT_W'(1);
        end
    end

endmodule

// File: rtl/vr_filter.sv
// Crank VR conditioning stage feeding the angle generator: glitch filter,
// active-edge selection, tooth period measurement, period-relative blanking
// of noise edges and stall detection.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no reference edge yet (after reset or a stall); blanking off
// FIRST | one edge seen; next accepted edge gives the first period
// RUN   | period valid; edges closer than the blank threshold are dropped
module vr_filter
    import vr_filter_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF,
    parameter int PER_W  = PER_W_DEF,
    parameter int REJ_W  = REJ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              edge_sel,
    input  logic [2:0]        blank_frac,
    output logic              cap,
    output logic              edge_stb,
    output logic [PER_W-1:0]  period,
    output logic              period_vld,
    output logic              stall,
    output logic [REJ_W-1:0]  rej_cnt
);

    logic             toggle;
    logic             cand;
    logic             accept;
    logic             reject;
    logic             pc_sat;
    logic             sat_evt;
    logic             acc_sat;
    logic             do_restart;
    logic             do_meas;
    logic [PER_W-1:0] pc;
    logic [PER_W-1:0] bt;
    logic [PER_W-1:0] acc_len;
    logic [PER_W-1:0] min_per;
    logic [PER_W-1:0] bt_new;
    logic [PER_W+2:0] blank_prod;
    state_t           state;
    state_t           state_nxt;

    vr_glitch_filter #(
        .FILT_W (FILT_W)
    ) u_glitch (
        .clk      (clk),
        .rst      (rst),
        .cap_in   (cap_in),
        .filt_len (filt_len),
        .cap      (cap),
        .toggle   (toggle)
    );

    // Candidate edge is a filter toggle in the selected direction; it is
    // accepted unless it lands inside the blanking window.
    always_comb begin
        cand = 1'b0;
        if (toggle) begin
            cand = (edge_sel == EDGE_RISE) ? ~cap : cap;
        end
        accept  = cand && (pc >= bt);
        reject  = cand && !accept;
        pc_sat  = &pc;
        sat_evt = pc_sat && !accept;
    end

    // Blank threshold from the shorter of the new and the outgoing period, so
    // the tooth after the missing-tooth gap is judged against a normal tooth.
    always_comb begin
        min_per    = acc_len;
        if ((state == RUN) && (period < acc_len)) begin
            min_per = period;
        end
        blank_prod = {3'b000, min_per} * {{PER_W{1'b0}}, blank_frac};
        bt_new     = blank_prod[PER_W+2:3];
    end

    // Free-running period counter, restarted by each accepted edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (accept) begin
            pc <= PER_W'(1);
        end else if (!pc_sat) begin
            pc <= pc + PER_W'(1);
        end
    end

    // Register the accept strobe with the edge-to-edge length it closed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_stb <= 1'b0;
            acc_len  <= '0;
            acc_sat  <= 1'b0;
        end else begin
            edge_stb <= accept;
            if (accept) begin
                acc_len <= pc;
                acc_sat <= pc_sat;
            end
        end
    end

    // Count blanked edges, holding at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= '0;
        end else if (reject && !(&rej_cnt)) begin
            rej_cnt <= rej_cnt + REJ_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; an accept that closed a saturated count restarts the
    // measurement rather than reporting a bogus period.
    always_comb begin
        state_nxt = state;
        if (edge_stb) begin
            if (acc_sat) begin
                state_nxt = FIRST;
            end else begin
                case (state)
                    IDLE:    state_nxt = FIRST;
                    FIRST:   state_nxt = RUN;
                    RUN:     state_nxt = RUN;
                    default: state_nxt = IDLE;
                endcase
            end
        end
        if (sat_evt) begin
            state_nxt = IDLE;
        end
    end

    // FSM outputs: what the cycle after an accept does to the measurement.
    always_comb begin
        do_restart = edge_stb && ((state == IDLE) || acc_sat);
        do_meas    = edge_stb && !do_restart;
    end

    // Period, validity, stall flag and blank threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period     <= '0;
            period_vld <= 1'b0;
            stall      <= 1'b0;
            bt         <= '0;
        end else if (sat_evt) begin
            stall      <= 1'b1;
            period_vld <= 1'b0;
            bt         <= '0;
        end else if (do_restart) begin
            stall      <= 1'b0;
            period_vld <= 1'b0;
            bt         <= '0;
        end else if (do_meas) begin
            period     <= acc_len;
            period_vld <= 1'b1;
            bt         <= bt_new;
        end
    end

endmodule

// File: tb/tb_vr_filter.sv
// Bench for vr_filter: a wide-counter instance (PER_W=24) and a narrow one
// (PER_W=12, stalls quickly) share one stimulus. A cycle-level behavioural
// model predicts both; directed literal checks pin the model.
module tb_vr_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_in = 1'b0;
    logic [3:0]  filt_len = 4'd4;
    logic        edge_sel = 1'b0;
    logic [2:0]  blank_frac = 3'd0;

    logic        cap_a, stb_a, vld_a, stall_a;
    logic [23:0] per_a;
    logic [7:0]  rej_a;
    logic        cap_b, stb_b, vld_b, stall_b;
    logic [11:0] per_b;
    logic [7:0]  rej_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;

    always #5 clk = ~clk;

    vr_filter #(.FILT_W(4), .PER_W(24), .REJ_W(8)) u_a (
        .clk(clk), .rst(rst), .cap_in(cap_in), .filt_len(filt_len),
        .edge_sel(edge_sel), .blank_frac(blank_frac),
        .cap(cap_a), .edge_stb(stb_a), .period(per_a), .period_vld(vld_a),
        .stall(stall_a), .rej_cnt(rej_a)
    );

    vr_filter #(.FILT_W(4), .PER_W(12), .REJ_W(8)) u_b (
        .clk(clk), .rst(rst), .cap_in(cap_in), .filt_len(filt_len),
        .edge_sel(edge_sel), .blank_frac(blank_frac),
        .cap(cap_b), .edge_stb(stb_b), .period(per_b), .period_vld(vld_b),
        .stall(stall_b), .rej_cnt(rej_b)
    );

    logic        d_cap[2], d_stb[2], d_vld[2], d_stall[2];
    logic [23:0] d_per[2];
    logic [7:0]  d_rej[2];
    assign d_cap[0] = cap_a;   assign d_cap[1] = cap_b;
    assign d_stb[0] = stb_a;   assign d_stb[1] = stb_b;
    assign d_vld[0] = vld_a;   assign d_vld[1] = vld_b;
    assign d_stall[0] = stall_a; assign d_stall[1] = stall_b;
    assign d_per[0] = per_a;   assign d_per[1] = {12'd0, per_b};
    assign d_rej[0] = rej_a;   assign d_rej[1] = rej_b;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit cap;
        int ticks;   // clocks since last accepted edge, saturating
        bit stb;
        bit pend;    // an accept awaiting its measurement update
        int plen;
        bit psat;
        int seen;    // accepted edges since reset/stall (0, 1, 2+)
        int period;
        int bt;
        bit vld;
        bit stall;
        int rej;
    } mdl_t;

    mdl_t  m[2];
    bit    samp[0:19];   // cap_in as sampled at successive clocks, newest first
    int    pmax[2] = '{16777215, 4095};

    always @(posedge clk or posedge rst) begin : model
        mdl_t nm;
        bit   flip, newcap, cand, acc;
        int   mn, frac;
        if (rst) begin
            for (int k = 0; k < 20; k++) samp[k] <= 1'b0;
            for (int i = 0; i < 2; i++) m[i] <= '{default: 0};
        end else begin
            for (int k = 1; k < 20; k++) samp[k] <= samp[k-1];
            samp[0] <= cap_in;
            frac = int'(blank_frac);
            for (int i = 0; i < 2; i++) begin
                nm = m[i];
                // level flips once the latest filt_len+1 synchronised samples all disagree
                flip = 1'b1;
                for (int k = 0; k <= int'(filt_len); k++)
                    if (samp[1+k] == m[i].cap) flip = 1'b0;
                newcap = flip ? ~m[i].cap : m[i].cap;
                cand   = flip && (newcap == (edge_sel == 1'b0));
                acc    = cand && (m[i].ticks >= m[i].bt);
                if (m[i].pend) begin
                    if (m[i].seen == 0 || m[i].psat) begin
                        nm.seen = 1; nm.stall = 0; nm.vld = 0; nm.bt = 0;
                    end else if (m[i].seen == 1) begin
                        nm.period = m[i].plen; nm.vld = 1; nm.seen = 2;
                        nm.bt = (m[i].plen * frac) / 8;
                    end else begin
                        mn = (m[i].plen < m[i].period) ? m[i].plen : m[i].period;
                        nm.period = m[i].plen;
                        nm.bt = (mn * frac) / 8;
                    end
                end
                if (m[i].ticks == pmax[i] && !acc) begin
                    nm.stall = 1; nm.vld = 0; nm.bt = 0; nm.seen = 0;
                end
                if (cand && !acc && m[i].rej < 255) nm.rej = m[i].rej + 1;
                nm.stb   = acc;
                nm.pend  = acc;
                nm.plen  = m[i].ticks;
                nm.psat  = (m[i].ticks == pmax[i]);
                nm.ticks = acc ? 1 : ((m[i].ticks == pmax[i]) ? m[i].ticks : m[i].ticks + 1);
                nm.cap   = newcap;
                m[i] <= nm;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    string inst[2] = '{"A", "B"};

    task automatic cycle_check();
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk({inst[i], " cap"},    64'(d_cap[i]),   64'(m[i].cap));
                chk({inst[i], " stb"},    64'(d_stb[i]),   64'(m[i].stb));
                chk({inst[i], " period"}, 64'(d_per[i]),   64'(m[i].period));
                chk({inst[i], " vld"},    64'(d_vld[i]),   64'(m[i].vld));
                chk({inst[i], " stall"},  64'(d_stall[i]), 64'(m[i].stall));
                chk({inst[i], " rej"},    64'(d_rej[i]),   64'(m[i].rej));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        cycle_check();
    endtask

    task automatic step_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic drive_at(input int t, input logic v);
        step_until(t);
        cap_in = v;
    endtask

    // clocks until cap_a reaches want, -1 if it never does within 20
    task automatic measure(input logic want, output int k);
        k = -1;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (cap_a === want) begin
                k = j;
                break;
            end
        end
    endtask

    function automatic int T(input int x);
        return t0 + x;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int  k;
        bit  glitch_seen;

        repeat (3) step();
        chk("reset cap",    64'(cap_a),   0);
        chk("reset period", 64'(per_a),   0);
        chk("reset vld",    64'(vld_a),   0);
        chk("reset stall",  64'(stall_a), 0);
        chk("reset rej",    64'(rej_a),   0);
        rst = 1'b0;
        repeat (5) step();

        // filter latency, filt_len=4: 2 sync + 4 + 1
        cap_in = 1'b1;
        t0 = cyc;
        measure(1'b1, k);
        chk("latency filt_len=4", 64'(k), 7);
        chk("first edge stb", 64'(stb_a), 1);
        drive_at(T(100), 1'b0);

        // 4-clock glitch must not reach cap
        drive_at(T(300), 1'b1);
        drive_at(T(304), 1'b0);
        glitch_seen = 1'b0;
        while (cyc < T(320)) begin
            step();
            if (cap_a !== 1'b0) glitch_seen = 1'b1;
        end
        chk("glitch rejected", 64'(glitch_seen), 0);

        // 60-2 wheel, 2048-clock teeth, no blanking
        drive_at(T(2048), 1'b1);  drive_at(T(2148), 1'b0);
        step_until(T(2098));
        chk("period 2 edges", 64'(per_a), 2048);
        chk("vld 2 edges",    64'(vld_a), 1);
        drive_at(T(4096), 1'b1);  drive_at(T(4196), 1'b0);
        drive_at(T(6144), 1'b1);  drive_at(T(6244), 1'b0);
        // narrow instance stalls 4095 clocks after the accept at T(6151)
        step_until(T(6144 + 4101));
        chk("B stall before sat", 64'(stall_b), 0);
        step();
        chk("B stall at sat", 64'(stall_b), 1);
        chk("B vld at sat",   64'(vld_b),   0);
        drive_at(T(12288), 1'b1); drive_at(T(12388), 1'b0);
        step_until(T(12338));
        chk("period gap",          64'(per_a),   6144);
        chk("B vld after 1 edge",  64'(vld_b),   0);
        chk("B stall cleared",     64'(stall_b), 0);
        drive_at(T(14336), 1'b1); drive_at(T(14436), 1'b0);
        step_until(T(14386));
        chk("period after gap",    64'(per_a), 2048);
        chk("B vld after 2 edges", 64'(vld_b), 1);
        chk("B period",            64'(per_b), 2048);

        // blanking at half the reference period
        blank_frac = 3'd4;
        drive_at(T(16384), 1'b1); drive_at(T(16484), 1'b0);
        drive_at(T(17184), 1'b1);
        step_until(T(17191));
        chk("noise 800 cap",  64'(cap_a), 1);
        chk("noise 800 stb",  64'(stb_a), 0);
        drive_at(T(17204), 1'b0);
        step_until(T(17234));
        chk("noise 800 rej A", 64'(rej_a), 1);
        chk("noise 800 rej B", 64'(rej_b), 1);
        drive_at(T(18432), 1'b1); drive_at(T(18532), 1'b0);
        drive_at(T(19532), 1'b1);
        step_until(T(19539));
        chk("noise 1100 stb", 64'(stb_a), 1);
        drive_at(T(19552), 1'b0);
        drive_at(T(20480), 1'b1); drive_at(T(20580), 1'b0);
        step_until(T(20530));
        chk("period after noise", 64'(per_a), 948);
        drive_at(T(22528), 1'b1); drive_at(T(22628), 1'b0);
        drive_at(T(24576), 1'b1); drive_at(T(24676), 1'b0);
        drive_at(T(30720), 1'b1);
        step_until(T(30727));
        chk("gap tooth stb", 64'(stb_a), 1);
        drive_at(T(30820), 1'b0);
        step_until(T(30770));
        step_until(T(30830));
        chk("gap tooth period", 64'(per_a), 6144);
        chk("gap tooth rej",    64'(rej_a), 1);

        // falling-edge selection
        step_until(T(30840));
        edge_sel = 1'b1;
        drive_at(T(32768), 1'b1); drive_at(T(32868), 1'b0);
        drive_at(T(34816), 1'b1);
        step_until(T(34823));
        chk("falling: no stb on rise", 64'(stb_a), 0);
        drive_at(T(34916), 1'b0);
        step_until(T(34923));
        chk("falling: stb on fall", 64'(stb_a), 1);
        step_until(T(34966));
        chk("falling: period", 64'(per_a), 2048);

        // asynchronous reset mid-tooth
        drive_at(T(36864), 1'b1);
        step_until(T(36914));
        #2;
        rst = 1'b1;
        edge_sel = 1'b0;
        #1;
        chk("async rst cap A",   64'(cap_a),   0);
        chk("async rst stb A",   64'(stb_a),   0);
        chk("async rst per A",   64'(per_a),   0);
        chk("async rst vld A",   64'(vld_a),   0);
        chk("async rst stall B", 64'(stall_b), 0);
        chk("async rst rej A",   64'(rej_a),   0);
        chk("async rst rej B",   64'(rej_b),   0);
        step();
        rst = 1'b0;
        measure(1'b1, k);
        chk("latency after reset", 64'(k), 7);
        chk("stb after reset",     64'(stb_a), 1);

        // filt_len=0: cap follows the synchronised input one clock later
        repeat (20) step();
        filt_len = 4'd0;
        cap_in = 1'b0;
        measure(1'b0, k);
        chk("latency filt_len=0", 64'(k), 3);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
